// File: rtl/keypad_bcd_encoder.sv
// Keypad digit entry: sync, validate and debounce ten key lines,
// then emit one BCD digit with a single-cycle active-low load strobe.
module keypad_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       enablen,
  input  logic [9:0] keypad,
  output logic [3:0] data,
  output logic       loadn,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    HOLD
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pat_q, pat_d;
  logic [3:0]       data_q, data_d;
  logic             loadn_q, loadn_d;
  logic             busy_q;
  logic [9:0]       sync1_q, sync2_q;
  logic             key_valid;
  logic             key_none;
  logic             key_same;

  // True when exactly one key line is set.
  function automatic logic one_hot(input logic [9:0] p);
    return (p != 10'd0) && ((p & (p - 10'd1)) == 10'd0);
  endfunction

  // Index of the set bit in a one-hot pattern.
  function automatic logic [3:0] encode(input logic [9:0] p);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (p[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign key_valid = one_hot(sync2_q);
  assign key_none  = (sync2_q == 10'd0);
  assign key_same  = (sync2_q == pat_q);

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sync1_q <= 10'd0;
      sync2_q <= 10'd0;
    end else begin
      sync1_q <= keypad;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: capture, debounce, strobe, wait for release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    data_d  = data_q;
    loadn_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!enablen && key_valid) begin
          pat_d   = sync2_q;
          cnt_d   = CNT_ONE;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (enablen || !key_same) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = encode(pat_q);
          loadn_d = 1'b0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!key_none) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= 10'd0;
      data_q  <= 4'd0;
      loadn_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      loadn_q <= loadn_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign data  = data_q;
  assign loadn = loadn_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: directed and random key activity
// checked against a sample-stream reference model via a strobe queue.
module tb_keypad_bcd_encoder;

  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [3:0] d;
  } strobe_t;

  logic       clock = 1'b0;
  logic       clrn = 1'b1;
  logic       enablen = 1'b0;
  logic [9:0] keypad = 10'd0;
  logic [3:0] data;
  logic       loadn;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int edges = 0;

  strobe_t sbq[$];

  // reference model state
  logic [9:0] m_s1 = 10'd0;
  logic [9:0] m_s2 = 10'd0;
  logic [9:0] m_smp = 10'd0;
  logic [9:0] m_pat = 10'd0;
  int         m_run = 0;
  int         m_zeros = 0;
  bit         m_load = 1'b0;
  bit         m_hold = 1'b0;
  logic [3:0] m_data = 4'd0;
  bit         m_busy = 1'b0;

  keypad_bcd_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .clrn(clrn),
    .enablen(enablen),
    .keypad(keypad),
    .data(data),
    .loadn(loadn),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edges <= edges + 1;

  // Model: a press is accepted after D matching single-key samples
  // taken while enabled; afterwards D released samples re-arm entry.
  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_s1 = 10'd0;
      m_s2 = 10'd0;
      m_pat = 10'd0;
      m_run = 0;
      m_zeros = 0;
      m_load = 1'b0;
      m_hold = 1'b0;
      m_data = 4'd0;
      m_busy = 1'b0;
    end else begin
      m_smp = m_s2;
      m_s2 = m_s1;
      m_s1 = keypad;
      if (m_load) begin
        m_load = 1'b0;
        m_hold = 1'b1;
        m_zeros = 0;
      end else if (m_hold) begin
        if (m_smp == 10'd0) m_zeros++;
        else m_zeros = 0;
        if (m_zeros == D) m_hold = 1'b0;
      end else if (m_run > 0) begin
        if (enablen || m_smp != m_pat) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == D) begin
            m_run = 0;
            m_load = 1'b1;
            m_data = 4'($clog2(m_pat));
            sbq.push_back('{cyc: edges + 1, d: m_data});
          end
        end
      end else if (!enablen && $countones(m_smp) == 1) begin
        m_pat = m_smp;
        m_run = 1;
      end
      m_busy = m_load || m_hold || (m_run > 0);
    end
  end

  // Monitor: compare outputs each cycle, pop the queue on strobes.
  always @(negedge clock) begin
    if (mon_en) begin
      strobe_t e;
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy edge=%0d got=%0b exp=%0b",
                 edges, busy, m_busy);
      end
      checks++;
      if (data !== m_data) begin
        errors++;
        $display("FAIL data edge=%0d got=%0d exp=%0d",
                 edges, data, m_data);
      end
      checks++;
      if (loadn === 1'b0) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL strobe edge=%0d got=loadn0 exp=none",
                   edges);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != edges || e.d !== data) begin
            errors++;
            $display("FAIL strobe got=edge%0d/d%0d exp=edge%0d/d%0d",
                     edges, data, e.cyc, e.d);
          end
        end
      end else if (loadn !== 1'b1) begin
        errors++;
        $display("FAIL loadn edge=%0d got=%b exp=1", edges, loadn);
      end else if (sbq.size() != 0 && sbq[0].cyc <= edges) begin
        e = sbq.pop_front();
        errors++;
        $display("FAIL strobe got=missing exp=edge%0d/d%0d",
                 e.cyc, e.d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int dig, input int hold, input int rel);
    keypad = 10'd1 << dig;
    tick(hold);
    keypad = 10'd0;
    tick(rel);
  endtask

  task automatic wait_run(input int target, input string name);
    for (int i = 0; i < 40 && m_run != target; i++) tick(1);
    checks++;
    if (m_run != target) begin
      errors++;
      $display("FAIL %s got=run%0d exp=run%0d", name, m_run, target);
    end
  endtask

  initial begin
    #1;
    clrn = 1'b0;
    #1;
    mon_en = 1'b1;
    tick(3);
    clrn = 1'b1;
    tick(3);

    // clean press of digit 3
    press(3, 20, 8);

    // bounce on digit 7, stable hold, bounce on release
    for (int i = 0; i < 5; i++) begin
      keypad = (i % 2 == 0) ? 10'd1 << 7 : 10'd0;
      tick(2);
    end
    keypad = 10'd1 << 7;
    tick(12);
    keypad = 10'd0;
    tick(1);
    keypad = 10'd1 << 7;
    tick(2);
    keypad = 10'd0;
    tick(8);

    // two keys together
    keypad = 10'b0000100001;
    tick(12);
    keypad = 10'd0;
    tick(6);

    // disabled entry
    enablen = 1'b1;
    press(9, 12, 6);
    enablen = 1'b0;

    // enable withdrawn mid-debounce
    keypad = 10'd1 << 9;
    wait_run(2, "wait_run2");
    enablen = 1'b1;
    tick(4);
    keypad = 10'd0;
    enablen = 1'b0;
    tick(6);

    // sequence 1, 2, 5
    press(1, 8, 8);
    press(2, 8, 8);
    press(5, 8, 8);

    // reset the cycle before LOAD, key kept held
    keypad = 10'd1 << 4;
    wait_run(D - 1, "wait_run_last");
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    tick(12);
    keypad = 10'd0;
    tick(8);

    // random activity
    for (int s = 0; s < 60; s++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 6)
        keypad = 10'd1 << $urandom_range(0, 9);
      else if (kind < 8)
        keypad = 10'd0;
      else
        keypad = 10'($urandom_range(0, 1023));
      enablen = ($urandom_range(0, 5) == 0);
      tick($urandom_range(1, 10));
    end

    keypad = 10'd0;
    enablen = 1'b0;
    tick(12);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending got=%0d exp=0", sbq.size());
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_bcd_encoder.md
Name: keypad_bcd_encoder

Overview:
- Upstream digit-entry stage for the countdown timer.
- Takes ten raw active-high key lines (digits 0-9) and synchronises, validates and debounces them.
- Emits one BCD digit plus a single-cycle active-low load strobe per key press; the timer shifts that digit into its seconds/minutes chain.
- Entry is gated by an active-low enable from the oven controller, so digits are only accepted while the timer is idle.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press and to accept a release. Legal range 2-255.
- CNT_W, 8: width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, rising edge
- clrn  input  1  asynchronous active-low reset
- enablen  input  1  active-low entry enable. 0 = key entry allowed.
- keypad  input  10  raw key lines, keypad[i]=1 means digit i pressed. Asynchronous to clock.
- data  output  4  BCD code of the last accepted digit, 0-9
- loadn  output  1  active-low load strobe, low for exactly one cycle per accepted press
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: clrn=0 asynchronously forces the following.
  - sync1 = sync2 = 0.
  - state = IDLE, counter = 0, captured pattern = 0.
  - data = 4'd0, loadn = 1, busy = 0.
  - Reset mid-press aborts with no strobe. After release of reset, the key must be re-debounced from scratch.
- Input synchroniser: keypad passes through 2 flops (sync1, sync2). The FSM uses only sync2.
- Valid pattern: sync2 has exactly one bit set. Zero bits or two or more bits set is treated as "no valid key".
- IDLE:
  - If enablen=0 and sync2 is valid: capture the pattern, set counter=1, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If enablen=1, or sync2 differs from the captured pattern: go to IDLE, clear counter, no strobe.
  - Else if counter = DEBOUNCE_CYCLES-1: go to LOAD.
  - Else increment counter.
- LOAD (one cycle):
  - Entering LOAD registers data = index of the captured bit and loadn = 0.
  - Next edge: loadn = 1, counter = 0, go to HOLD unconditionally. An enablen change during LOAD has no effect.
- HOLD (wait for release):
  - If sync2 = 0: increment counter.
  - If sync2 is non-zero: counter = 0.
  - When sync2 = 0 and counter = DEBOUNCE_CYCLES-1: go to IDLE.
  - enablen is ignored in HOLD.
  - A held or bouncing key can never produce a second strobe.
- busy = 1 in DEBOUNCE, LOAD and HOLD. All outputs are registered; there are no combinational paths from input to output.
- data holds its value between strobes. It changes only on the edge where loadn falls.
- Latency: keypad goes stable before edge t0. sync2 shows it at t0+1. The first FSM sample is at t0+2. loadn falls at edge t0+1+DEBOUNCE_CYCLES (t0+5 at default).
- Minimum press-to-press spacing: DEBOUNCE_CYCLES of released samples, plus DEBOUNCE_CYCLES pressed samples, plus 1.
- Key change between two single digits during DEBOUNCE: abort to IDLE. The new key is captured on the next IDLE sample, so the count restarts.

Test Plan:
- Clean press, default parameters: keypad=10'b0000001000 held 20 cycles with enablen=0. Expected: loadn low for exactly 1 cycle at edge t0+5, data=4'd3, busy high until 4 cycles after sync2 returns to 0. No second strobe.
- Bounce: keypad toggles digit 7 on/off every 2 cycles for 10 cycles, then holds stable. Expected: no strobe during the bounce, and one strobe with data=4'd7 after 4 stable samples. Bounce on release gives no extra strobe.
- Two keys: keypad=10'b0000100001 (digits 0 and 5) held. Expected: loadn stays 1, busy stays 0, data unchanged.
- Enable gating:
  - Press digit 9 with enablen=1: expected no strobe, busy=0.
  - Deassert enablen (drive it 1) during DEBOUNCE at counter=2: expected return to IDLE, no strobe.
- Sequence 1,2,5 with full release between presses: expected exactly three strobes with data 1, 2, 5 in that order. data holds 5 afterwards.
- Reset mid-operation: assert clrn=0 in the cycle before LOAD. Expected: immediate data=0, loadn=1, busy=0. After reset release with the key still held, a fresh full debounce runs, then one strobe.
